// File: rtl/usr_seq.sv
// Drives a usr shift register: loads a word, shifts it out on sdo while capturing sdi, returns rx_data.
// Latency accept->rx_valid = data_bitsize*shift_div+2 edges; tx_ready only in IDLE (back-to-back allowed).
module usr_seq #(
   parameter int data_bitsize = 4,
   parameter int shift_div    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [data_bitsize-1:0] tx_data,
   input  logic                    tx_dir,
   input  logic                    sdi,
   output logic                    sdo,
   output logic                    busy,
   output logic                    rx_valid,
   output logic [data_bitsize-1:0] rx_data,
   output logic [1:0]              usr_sel,
   output logic [data_bitsize-1:0] usr_datain,
   output logic                    usr_sin,
   input  logic [data_bitsize-1:0] usr_out
);
   localparam int BW = $clog2(data_bitsize);
   localparam int DW = (shift_div > 1) ? $clog2(shift_div) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(data_bitsize - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(shift_div - 1);

   localparam logic [1:0] SEL_CLR  = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t                  state_q;
   logic [BW-1:0]           bit_cnt_q;
   logic [DW-1:0]           div_cnt_q;
   logic [data_bitsize-1:0] data_q;
   logic                    dir_q;
   logic [data_bitsize-1:0] rx_data_q;
   logic                    rx_valid_q;
   logic                    div_last;

   assign div_last = (div_cnt_q == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         data_q     <= '0;
         dir_q      <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_valid) begin
                  data_q  <= tx_data;
                  dir_q   <= tx_dir;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               bit_cnt_q <= '0;
               div_cnt_q <= '0;
               state_q   <= SHIFT;
            end
            SHIFT: begin
               if (div_last) begin
                  div_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= DONE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            DONE: begin
               rx_data_q  <= usr_out;
               rx_valid_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The register has no hold code, so "hold" is a parallel load of its own output.
   always_comb begin
      usr_sel    = SEL_CLR;
      usr_datain = '0;
      usr_sin    = 1'b0;
      sdo        = 1'b0;
      case (state_q)
         LOAD: begin
            usr_sel    = SEL_LOAD;
            usr_datain = data_q;
         end
         SHIFT: begin
            usr_sin    = sdi;
            sdo        = dir_q ? usr_out[data_bitsize-1] : usr_out[0];
            usr_datain = usr_out;
            usr_sel    = div_last ? (dir_q ? SEL_SHL : SEL_SHR) : SEL_LOAD;
         end
         DONE: begin
            usr_sel    = SEL_LOAD;
            usr_datain = usr_out;
         end
         default: ;
      endcase
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_usr_seq.sv
// Two controllers (shift_div 1 and 3), each driving a behavioural usr register, checked against bit-order rules.
`timescale 1ns/1ps
module tb_usr_seq;
   logic       clk;
   logic       rst_n      [2];
   logic       tx_valid   [2];
   logic       tx_ready   [2];
   logic [3:0] tx_data    [2];
   logic       tx_dir     [2];
   logic       sdi        [2];
   logic       sdo        [2];
   logic       busy       [2];
   logic       rx_valid   [2];
   logic [3:0] rx_data    [2];
   logic [1:0] usr_sel    [2];
   logic [3:0] usr_datain [2];
   logic       usr_sin    [2];
   logic [3:0] usr_q      [2];
   logic [3:0] last_rx    [2];

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   usr_seq #(.data_bitsize(4), .shift_div(1)) u_dut_d1 (
      .clk(clk), .reset(rst_n[0]),
      .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_dir(tx_dir[0]),
      .sdi(sdi[0]), .sdo(sdo[0]), .busy(busy[0]),
      .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
      .usr_sel(usr_sel[0]), .usr_datain(usr_datain[0]), .usr_sin(usr_sin[0]), .usr_out(usr_q[0])
   );

   usr_seq #(.data_bitsize(4), .shift_div(3)) u_dut_d3 (
      .clk(clk), .reset(rst_n[1]),
      .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_dir(tx_dir[1]),
      .sdi(sdi[1]), .sdo(sdo[1]), .busy(busy[1]),
      .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
      .usr_sel(usr_sel[1]), .usr_datain(usr_datain[1]), .usr_sin(usr_sin[1]), .usr_out(usr_q[1])
   );

   // Behavioural universal shift register (no reset of its own).
   initial begin
      usr_q[0] = 4'h0;
      usr_q[1] = 4'h0;
   end
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         case (usr_sel[i])
            2'b00: usr_q[i] <= 4'h0;
            2'b01: usr_q[i] <= {usr_sin[i], usr_q[i][3:1]};
            2'b10: usr_q[i] <= {usr_q[i][2:0], usr_sin[i]};
            default: usr_q[i] <= usr_datain[i];
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input int k);
      check_eq("rst_busy",     32'(busy[k]),     32'd0);
      check_eq("rst_tx_ready", 32'(tx_ready[k]), 32'd1);
      check_eq("rst_sdo",      32'(sdo[k]),      32'd0);
      check_eq("rst_usr_sel",  32'(usr_sel[k]),  32'd0);
      check_eq("rst_rx_valid", 32'(rx_valid[k]), 32'd0);
      check_eq("rst_rx_data",  32'(rx_data[k]),  32'd0);
   endtask

   // Call away from a rising edge with the DUT idle; returns at the falling edge of the rx_valid cycle.
   // hold keeps tx_valid high with junk tx_data/tx_dir while the transfer runs.
   task automatic xfer(input int k, input logic [3:0] d, input logic dir,
                       input logic [3:0] sb, input logic hold);
      int         div = (k == 0) ? 1 : 3;
      logic [3:0] exp_rx;
      logic [1:0] exp_sel;
      tx_valid[k] = 1'b1;
      tx_data[k]  = d;
      tx_dir[k]   = dir;
      check_eq("idle_tx_ready", 32'(tx_ready[k]), 32'd1);
      @(posedge clk);
      #1;
      tx_valid[k] = hold;
      tx_data[k]  = ~d;
      tx_dir[k]   = ~dir;
      @(negedge clk);
      check_eq("load_busy",   32'(busy[k]),       32'd1);
      check_eq("load_sel",    32'(usr_sel[k]),    32'd3);
      check_eq("load_datain", 32'(usr_datain[k]), 32'(d));
      check_eq("load_sdo",    32'(sdo[k]),        32'd0);
      check_eq("load_rxv",    32'(rx_valid[k]),   32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < div; c++) begin
            sdi[k] = sb[i];
            if (hold) tx_data[k] = 4'($urandom);
            @(negedge clk);
            exp_sel = (c == div - 1) ? (dir ? 2'b10 : 2'b01) : 2'b11;
            check_eq("shift_sdo",      32'(sdo[k]),      32'(dir ? d[3-i] : d[i]));
            check_eq("shift_sel",      32'(usr_sel[k]),  32'(exp_sel));
            check_eq("shift_tx_ready", 32'(tx_ready[k]), 32'd0);
            check_eq("shift_rxv",      32'(rx_valid[k]), 32'd0);
            @(posedge clk);
            #1;
         end
      end
      sdi[k] = 1'($urandom);
      @(negedge clk);
      check_eq("done_sel",  32'(usr_sel[k]),  32'd3);
      check_eq("done_sdo",  32'(sdo[k]),      32'd0);
      check_eq("done_busy", 32'(busy[k]),     32'd1);
      check_eq("done_rxv",  32'(rx_valid[k]), 32'd0);
      @(posedge clk);
      #1;
      tx_valid[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (dir) exp_rx[3-i] = sb[i];
         else     exp_rx[i]   = sb[i];
      end
      @(negedge clk);
      check_eq("rx_valid",      32'(rx_valid[k]), 32'd1);
      check_eq("rx_data",       32'(rx_data[k]),  32'(exp_rx));
      check_eq("rxv_tx_ready",  32'(tx_ready[k]), 32'd1);
      check_eq("rxv_busy",      32'(busy[k]),     32'd0);
      check_eq("rxv_sel",       32'(usr_sel[k]),  32'd0);
      last_rx[k] = exp_rx;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_n[k]    = 1'b0;
         tx_valid[k] = 1'b0;
         tx_data[k]  = 4'h0;
         tx_dir[k]   = 1'b0;
         sdi[k]      = 1'b0;
         last_rx[k]  = 4'h0;
      end
      #1;
      check_reset_outputs(0);
      check_reset_outputs(1);
      repeat (3) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // Directed vectors; the first accept lands on the first edge after release.
      xfer(0, 4'b1011, 1'b0, 4'b1001, 1'b0);
      xfer(0, 4'b1011, 1'b1, 4'b0110, 1'b0);
      xfer(1, 4'b0110, 1'b0, 4'b1111, 1'b0);
      xfer(0, 4'hA, 1'b0, 4'($urandom), 1'b1);
      xfer(0, 4'h5, 1'b1, 4'($urandom), 1'b1);

      // Reset dropped in during the second SHIFT cycle.
      @(posedge clk);
      #1;
      tx_valid[0] = 1'b1;
      tx_data[0]  = 4'b1100;
      tx_dir[0]   = 1'b0;
      @(posedge clk);
      #1;
      tx_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n[0] = 1'b0;
      #1;
      check_reset_outputs(0);
      repeat (8) begin
         @(negedge clk);
         check_eq("inrst_rxv",  32'(rx_valid[0]), 32'd0);
         check_eq("inrst_busy", 32'(busy[0]),     32'd0);
      end
      rst_n[0]   = 1'b1;
      last_rx[0] = 4'h0;
      xfer(0, 4'b0011, 1'b1, 4'b1010, 1'b0);

      // Idle: register cleared, rx_data retained.
      xfer(1, 4'h9, 1'b1, 4'b0100, 1'b0);
      repeat (10) begin
         @(negedge clk);
         check_eq("idle_sel",    32'(usr_sel[1]),    32'd0);
         check_eq("idle_busy",   32'(busy[1]),       32'd0);
         check_eq("idle_rxv",    32'(rx_valid[1]),   32'd0);
         check_eq("idle_rxdata", 32'(rx_data[1]),    32'(last_rx[1]));
         check_eq("idle_datain", 32'(usr_datain[1]), 32'd0);
      end

      // Randomized transfers with random gaps (gap 0 = back-to-back).
      for (int r = 0; r < 40; r++) begin
         int k;
         int gap;
         k   = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         xfer(k, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/usr_seq.md
# usr_seq

Sequencing controller for the `usr` universal shift register (same `data_bitsize`). It accepts a parallel word over a valid/ready handshake and loads it into the register. It then shifts the word out serially on `sdo` while capturing `sdi`, and returns the received word on `rx_data` with a one-cycle `rx_valid` pulse. It sits between a parallel producer/consumer and a serial link, and owns every `sel`/`sin`/`datain` drive of the register.

## Interface
- `data_bitsize`, 4: word width; must match the controlled `usr`; ≥ 2.
- `shift_div`, 1: clk cycles per serial bit; ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  controller can accept a word.
- `tx_data`  in  data_bitsize  word to transmit.
- `tx_dir`  in  1  0 = right (LSB first), 1 = left (MSB first); sampled on accept.
- `sdi`  in  1  serial input bit.
- `sdo`  out  1  serial output bit.
- `busy`  out  1  transfer in progress (any state other than IDLE).
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid.
- `rx_data`  out  data_bitsize  received word.
- `usr_sel`  out  2  to `usr.sel`.
- `usr_datain`  out  data_bitsize  to `usr.datain`.
- `usr_sin`  out  1  to `usr.sin`.
- `usr_out`  in  data_bitsize  from `usr.out`.

## Operation
- Register contract used by this block:
  - 00: clear.
  - 01: shift right, `sin` enters the MSB and bit 0 leaves.
  - 10: shift left, `sin` enters the LSB and the MSB leaves.
  - 11: parallel load `datain`.
  - There is no hold code. The controller holds the register by driving 11 with `usr_datain = usr_out`.
- FSM states: IDLE, LOAD, SHIFT, DONE. The state, bit counter (0..data_bitsize-1), divider counter (0..shift_div-1), latched data, latched direction, `rx_data` and `rx_valid` are registers. `usr_*`, `sdo`, `tx_ready` and `busy` are combinational from state.
- IDLE:
  - `usr_sel=00` (register cleared every cycle), `tx_ready=1`.
  - On `tx_valid & tx_ready`: latch `tx_data` and `tx_dir`, go to LOAD.
- LOAD (1 cycle):
  - `usr_sel=11`, `usr_datain` = latched data.
  - Clear both counters, go to SHIFT.
- SHIFT:
  - `usr_sin=sdi`.
  - `sdo = usr_out[0]` (right) or `usr_out[data_bitsize-1]` (left).
  - Divider counter < shift_div-1: `usr_sel=11`, `usr_datain=usr_out` (hold), divider counter +1.
  - Divider counter = shift_div-1: `usr_sel` = 01 (right) or 10 (left), divider counter → 0, bit counter +1.
  - After the shift that occurs when the bit counter = data_bitsize-1, go to DONE.
- DONE (1 cycle):
  - Hold the register (11 with `usr_out`).
  - At the exit edge: `rx_data <= usr_out`, `rx_valid <= 1`, go to IDLE.
- `rx_valid` is high for exactly one cycle. `rx_data` holds its value until the next capture.
- `sdo=0` and `usr_sin=0` outside SHIFT. `usr_datain=0` in IDLE.
- Received bit order:
  - Right: the first `sdi` bit lands in bit 0 and the last in the MSB.
  - Left: the first `sdi` bit lands in the MSB and the last in bit 0.
- `tx_valid` outside IDLE is ignored (not accepted, no side effects). `tx_data` and `tx_dir` changes after accept do not affect the transfer.

## Timing
- Reset (async assert, any state, including mid-transfer):
  - State IDLE, counters 0, `rx_data=0`, `rx_valid=0`, `busy=0`, `tx_ready=1`, `sdo=0`, `usr_sel=00`.
  - The in-flight transfer is dropped and no `rx_valid` is produced.
  - Release is synchronized by the standard flow; the first accept can occur on the first edge after release.
- Latency from accept edge E:
  - LOAD occupies cycle E+1.
  - SHIFT occupies data_bitsize·shift_div cycles.
  - DONE occupies 1 cycle.
  - `rx_valid` is high in the cycle after edge E + data_bitsize·shift_div + 2.
- Throughput: `tx_ready` returns high in the same cycle `rx_valid` is high. Accept in that cycle is allowed (back-to-back), giving a period of data_bitsize·shift_div + 3 cycles.
- `sdo` is stable for each full shift_div-cycle bit period. `sdi` is sampled on the last edge of each bit period.

## Test plan
- data_bitsize=4, shift_div=1: accept `tx_data=4'b1011` with dir=0, drive `sdi` 1,0,0,1. Required: `sdo` = 1,1,0,1; `rx_data=4'b1001`; `rx_valid` a single pulse 6 edges after accept.
- Same with dir=1, `sdi` 0,1,1,0. Required: `sdo` = 1,0,1,1; `rx_data=4'b0110`.
- shift_div=3, dir=0, `tx_data=4'b0110`, `sdi` held 1. Required: each `sdo` bit lasts 3 cycles (0,1,1,0); `rx_data=4'b1111`; `rx_valid` 14 edges after accept.
- Back-to-back: `tx_valid` held high with 4'hA then 4'h5. Required: second accept in the `rx_valid` cycle; period 7 cycles; `tx_valid` during SHIFT not accepted.
- Reset asserted during the 2nd SHIFT cycle. Required: all outputs immediately at reset values, `usr_sel=00`, no `rx_valid`; the next transfer after release completes normally.
- In IDLE with `tx_valid=0` for 10 cycles. Required: `usr_sel=00`, `busy=0`, `rx_valid=0` throughout; `rx_data` keeps its previous value.
